// File: rtl/wb_lsi_pkg.sv
// Shared types and constants for the Wishbone-to-LSI initiator bridge.
// Optional response watchdog is enabled by defining WB_LSI_INITIATOR_WATCHDOG_EN.
package wb_lsi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } wb_lsi_state_e;

    localparam logic [2:0] LSI_OPC_READ  = 3'b000;
    localparam logic [2:0] LSI_OPC_WRITE = 3'b001;

    localparam logic [1:0] LSI_ERR_OK  = 2'b00;
    localparam logic [1:0] LSI_ERR_BUS = 2'b01;

    localparam int unsigned LSI_ADDR_W = 13;

    // Only full-word accesses inside the 13-bit LSI word space are forwarded.
    function automatic logic wb_req_legal(input logic [3:0] sel, input logic [29:0] adr);
        return (sel == 4'hF) && (adr[29:LSI_ADDR_W] == '0);
    endfunction

endpackage

// File: rtl/wb_lsi_watchdog.sv
// Saturating response watchdog: counts enabled cycles since the last clear and
// flags expiry once LIMIT-1 is reached. Used only with WB_LSI_INITIATOR_WATCHDOG_EN.
module wb_lsi_watchdog #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(LIMIT);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/wb_lsi_initiator.sv
// Wishbone B3 classic slave to LSI initiator bridge: one LSI read/write per Wishbone
// cycle. Define WB_LSI_INITIATOR_WATCHDOG_EN to add the response watchdog and DRAIN state.
module wb_lsi_initiator
    import wb_lsi_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic          host_clk_i,
    input  logic          host_rst_ni,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic          wb_we_i,
    input  logic [29:0]   wb_adr_i,
    input  logic [31:0]   wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    output logic [31:0]   wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          lsioc_rx_vld_o,
    output logic [12:0]   lsioc_rx_sbsp_o,
    output logic [31:0]   lsioc_rx_data_o,
    output logic [2:0]    lsioc_rx_opc_o,
    input  logic          lsioc_rx_busy_i,
    input  logic          lsioc_tx_vld_i,
    input  logic [31:0]   lsioc_tx_data_i,
    input  logic [1:0]    lsioc_tx_err_code_i,
    output logic          lsioc_tx_busy_o,
    output wb_lsi_state_e dbg_state
);

    // Handshakes: a request transfers on a clock edge where rx_vld=1 and rx_busy=0;
    // payload and rx_vld are held unchanged until then. A response transfers on an
    // edge where tx_vld=1 and tx_busy=0; tx_vld seen while tx_busy=1 is ignored.

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
        $error("wb_lsi_initiator: TIMEOUT_CYCLES must be at least 2");
    end

    wb_lsi_state_e state_q, state_d;

    logic [12:0] sbsp_q;
    logic [31:0] wdata_q;
    logic [2:0]  opc_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        drain_q;

    logic req_take;
    logic req_bad;
    logic rsp_take;
    logic timeout;
    logic drain_set;
    logic wd_expired;

`ifdef WB_LSI_INITIATOR_WATCHDOG_EN
    logic wd_enable;

    assign wd_enable = (state_q == ST_REQ) || (state_q == ST_WAIT);

    wb_lsi_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (host_clk_i),
        .rst_n   (host_rst_ni),
        .clear   (req_take),
        .enable  (wd_enable),
        .expired (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge host_clk_i or negedge host_rst_ni) begin
        if (!host_rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_take  = 1'b0;
        req_bad   = 1'b0;
        rsp_take  = 1'b0;
        timeout   = 1'b0;
        drain_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    if (wb_req_legal(wb_sel_i, wb_adr_i)) begin
                        req_take = 1'b1;
                        state_d  = ST_REQ;
                    end else begin
                        req_bad = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_REQ: begin
                // An accepted request wins over a same-cycle expiry so the responder
                // never sees a request the initiator has abandoned.
                if (!lsioc_rx_busy_i) begin
                    state_d = ST_WAIT;
                end else if (wd_expired) begin
                    timeout = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_WAIT: begin
                if (lsioc_tx_vld_i) begin
                    rsp_take = 1'b1;
                    state_d  = ST_RESP;
                end else if (wd_expired) begin
                    timeout   = 1'b1;
                    drain_set = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = drain_q ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                if (lsioc_tx_vld_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge host_clk_i or negedge host_rst_ni) begin
        if (!host_rst_ni) begin
            sbsp_q  <= '0;
            wdata_q <= '0;
            opc_q   <= LSI_OPC_READ;
            rdata_q <= '0;
            err_q   <= 1'b0;
            drain_q <= 1'b0;
        end else begin
            if (req_take) begin
                sbsp_q  <= wb_adr_i[LSI_ADDR_W-1:0];
                wdata_q <= wb_dat_i;
                opc_q   <= wb_we_i ? LSI_OPC_WRITE : LSI_OPC_READ;
            end
            if (rsp_take) begin
                rdata_q <= lsioc_tx_data_i;
                err_q   <= (lsioc_tx_err_code_i != LSI_ERR_OK);
            end else if (req_bad || timeout) begin
                err_q <= 1'b1;
            end
            // The late response of a timed-out exchange must be swallowed exactly once.
            if (drain_set) begin
                drain_q <= 1'b1;
            end else if (state_q == ST_DRAIN) begin
                drain_q <= 1'b0;
            end
        end
    end

    assign lsioc_rx_vld_o  = (state_q == ST_REQ);
    assign lsioc_rx_sbsp_o = sbsp_q;
    assign lsioc_rx_data_o = wdata_q;
    assign lsioc_rx_opc_o  = opc_q;
    assign lsioc_tx_busy_o = !((state_q == ST_WAIT) || (state_q == ST_DRAIN));

    assign wb_ack_o = (state_q == ST_RESP) && !err_q;
    assign wb_err_o = (state_q == ST_RESP) && err_q;
    assign wb_dat_o = rdata_q;

    assign dbg_state = state_q;

endmodule

// File: tb/tb_wb_lsi_initiator.sv
// Directed self-checking bench for wb_lsi_initiator: table of single transactions plus
// hand sequences for reset mid-WAIT and, with WB_LSI_INITIATOR_WATCHDOG_EN, the watchdog.
`timescale 1ns/1ps
module tb_wb_lsi_initiator;
    import wb_lsi_pkg::*;

    localparam int unsigned TIMEOUT = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wb_cyc = 1'b0;
    logic          wb_stb = 1'b0;
    logic          wb_we = 1'b0;
    logic [29:0]   wb_adr = '0;
    logic [31:0]   wb_dat = '0;
    logic [3:0]    wb_sel = '0;
    logic [31:0]   wb_rdat;
    logic          wb_ack;
    logic          wb_err;
    logic          rx_vld;
    logic [12:0]   rx_sbsp;
    logic [31:0]   rx_data;
    logic [2:0]    rx_opc;
    logic          rx_busy = 1'b0;
    logic          tx_vld = 1'b0;
    logic [31:0]   tx_data = '0;
    logic [1:0]    tx_err = '0;
    logic          tx_busy;
    wb_lsi_state_e dbg_state;

    always #5 clk = ~clk;

    wb_lsi_initiator #(
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .host_clk_i          (clk),
        .host_rst_ni         (rst_n),
        .wb_cyc_i            (wb_cyc),
        .wb_stb_i            (wb_stb),
        .wb_we_i             (wb_we),
        .wb_adr_i            (wb_adr),
        .wb_dat_i            (wb_dat),
        .wb_sel_i            (wb_sel),
        .wb_dat_o            (wb_rdat),
        .wb_ack_o            (wb_ack),
        .wb_err_o            (wb_err),
        .lsioc_rx_vld_o      (rx_vld),
        .lsioc_rx_sbsp_o     (rx_sbsp),
        .lsioc_rx_data_o     (rx_data),
        .lsioc_rx_opc_o      (rx_opc),
        .lsioc_rx_busy_i     (rx_busy),
        .lsioc_tx_vld_i      (tx_vld),
        .lsioc_tx_data_i     (tx_data),
        .lsioc_tx_err_code_i (tx_err),
        .lsioc_tx_busy_o     (tx_busy),
        .dbg_state           (dbg_state)
    );

    typedef struct {
        logic        we;
        logic [29:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          busy_cycles;  // rx_busy high for cycles 1..busy_cycles
        int          gap;          // idle WAIT cycles before tx_vld
        int          drop_at;      // master drops cyc/stb from this cycle (0 = never)
        logic [31:0] rsp_data;
        logic [1:0]  rsp_code;
        int          exp_resp_cyc;
        logic        exp_ack;
        logic        exp_err;
        logic [31:0] exp_dat;
        int          exp_vld_cycles;
        int          exp_accepts;
        logic [12:0] exp_sbsp;
        logic [2:0]  exp_opc;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];
    vec_t vecs[9];

    function automatic vec_t mk(
        input logic we, input logic [29:0] adr, input logic [31:0] dat, input logic [3:0] sel,
        input int busy, input int gap, input int drop, input logic [31:0] rdat, input logic [1:0] code,
        input int ecyc, input logic eack, input logic eerr, input logic [31:0] edat,
        input int evld, input int eacc, input logic [12:0] esbsp, input logic [2:0] eopc);
        vec_t v;
        v.we = we; v.adr = adr; v.dat = dat; v.sel = sel;
        v.busy_cycles = busy; v.gap = gap; v.drop_at = drop;
        v.rsp_data = rdat; v.rsp_code = code;
        v.exp_resp_cyc = ecyc; v.exp_ack = eack; v.exp_err = eerr; v.exp_dat = edat;
        v.exp_vld_cycles = evld; v.exp_accepts = eacc; v.exp_sbsp = esbsp; v.exp_opc = eopc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rx_vld"}, 32'(rx_vld), 32'd0);
        check({tag, "_rx_sbsp"}, 32'(rx_sbsp), 32'd0);
        check({tag, "_rx_data"}, rx_data, 32'd0);
        check({tag, "_rx_opc"}, 32'(rx_opc), 32'd0);
        check({tag, "_ack"}, 32'(wb_ack), 32'd0);
        check({tag, "_err"}, 32'(wb_err), 32'd0);
        check({tag, "_wb_dat"}, wb_rdat, 32'd0);
        check({tag, "_tx_busy"}, 32'(tx_busy), 32'd1);
        check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    // Cycle 0 presents stb (sampled at edge 0); cycle c is observed at its falling edge.
    task automatic run_vec(input vec_t v, input string tag);
        int resp_cyc, ack_cnt, err_cnt, vld_cnt, acc_cnt, accept_cyc, tx_cyc, pay_bad, busy_bad;
        logic [31:0] ack_dat;
        resp_cyc = -1; ack_cnt = 0; err_cnt = 0; vld_cnt = 0; acc_cnt = 0;
        accept_cyc = -1; tx_cyc = -1; pay_bad = 0; busy_bad = 0; ack_dat = '0;
        if (v.exp_ack) exp_q.push_back(v.exp_dat);
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = v.we; wb_adr = v.adr; wb_dat = v.dat; wb_sel = v.sel;
        rx_busy = 1'b0; tx_vld = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (resp_cyc > 0 || (v.drop_at > 0 && c >= v.drop_at)) begin
                wb_cyc = 1'b0; wb_stb = 1'b0;
            end
            rx_busy = (c <= v.busy_cycles);
            tx_vld = (accept_cyc > 0 && c == accept_cyc + 1 + v.gap);
            if (tx_vld) begin
                tx_data = v.rsp_data; tx_err = v.rsp_code; tx_cyc = c;
            end else begin
                tx_data = $urandom(); tx_err = 2'($urandom_range(0, 3));
            end
            @(negedge clk);
            if (rx_vld) begin
                vld_cnt++;
                if (rx_sbsp !== v.exp_sbsp || rx_data !== v.dat || rx_opc !== v.exp_opc) pay_bad++;
                if (tx_busy !== 1'b1) busy_bad++;
                if (!rx_busy) begin
                    acc_cnt++;
                    accept_cyc = c;
                end
            end
            if (wb_ack) begin
                ack_cnt++;
                ack_dat = wb_rdat;
                if (resp_cyc < 0) resp_cyc = c;
            end
            if (wb_err) begin
                err_cnt++;
                if (resp_cyc < 0) resp_cyc = c;
            end
            if (accept_cyc > 0 && c > accept_cyc && resp_cyc < 0 && tx_busy !== 1'b0) busy_bad++;
            if (resp_cyc > 0 && c >= resp_cyc + 2) break;
        end
        @(posedge clk); #1;
        tx_vld = 1'b0; rx_busy = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
        check({tag, "_resp_cycle"}, 32'(resp_cyc), 32'(v.exp_resp_cyc));
        check({tag, "_ack_pulses"}, 32'(ack_cnt), 32'(v.exp_ack));
        check({tag, "_err_pulses"}, 32'(err_cnt), 32'(v.exp_err));
        check({tag, "_rx_vld_cycles"}, 32'(vld_cnt), 32'(v.exp_vld_cycles));
        check({tag, "_accepts"}, 32'(acc_cnt), 32'(v.exp_accepts));
        check({tag, "_payload_unstable"}, 32'(pay_bad), 32'd0);
        check({tag, "_tx_busy_protocol"}, 32'(busy_bad), 32'd0);
        if (v.exp_ack) begin
            check({tag, "_ack_data"}, ack_dat, exp_q.pop_front());
            @(negedge clk);
            check({tag, "_dat_held"}, wb_rdat, v.exp_dat);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        int stray;
        int waited;
        //                  we    adr            dat           sel   bsy gap drp rsp_data      code         cyc ack   err   exp_dat       vld acc sbsp      opc
        vecs[0] = mk(1'b0, 30'h0000_0004, 32'h0,        4'hF, 0, 1, 0, 32'hDEAD_BEEF, LSI_ERR_OK,  4,  1'b1, 1'b0, 32'hDEAD_BEEF, 1, 1, 13'h0004, LSI_OPC_READ);
        vecs[1] = mk(1'b1, 30'h0000_1FFF, 32'h1234_5678, 4'hF, 5, 0, 0, 32'hA5A5_0001, LSI_ERR_OK,  8,  1'b1, 1'b0, 32'hA5A5_0001, 6, 1, 13'h1FFF, LSI_OPC_WRITE);
        vecs[2] = mk(1'b0, 30'h0000_0100, 32'h0,        4'hF, 0, 0, 0, 32'hCAFE_F00D, LSI_ERR_BUS, 3,  1'b0, 1'b1, 32'h0,         1, 1, 13'h0100, LSI_OPC_READ);
        vecs[3] = mk(1'b0, 30'h0000_0010, 32'h0,        4'h3, 0, 0, 0, 32'h0,         LSI_ERR_OK,  1,  1'b0, 1'b1, 32'h0,         0, 0, 13'h0000, LSI_OPC_READ);
        vecs[4] = mk(1'b1, 30'h0000_2000, 32'h1,        4'hF, 0, 0, 0, 32'h0,         LSI_ERR_OK,  1,  1'b0, 1'b1, 32'h0,         0, 0, 13'h0000, LSI_OPC_READ);
        vecs[5] = mk(1'b0, 30'h0000_0ABC, 32'h0,        4'hF, 2, 3, 0, 32'h0F0F_1234, 2'b11,       8,  1'b0, 1'b1, 32'h0,         3, 1, 13'h0ABC, LSI_OPC_READ);
        vecs[6] = mk(1'b1, 30'h0000_0000, 32'h55AA_55AA, 4'hF, 1, 2, 0, 32'h600D_DA7A, LSI_ERR_OK,  6,  1'b1, 1'b0, 32'h600D_DA7A, 2, 1, 13'h0000, LSI_OPC_WRITE);
        vecs[7] = mk(1'b0, 30'h0000_0042, 32'h0,        4'hF, 1, 1, 2, 32'h1357_2468, LSI_ERR_OK,  5,  1'b1, 1'b0, 32'h1357_2468, 2, 1, 13'h0042, LSI_OPC_READ);
        vecs[8] = mk(1'b0, 30'h2000_0000, 32'h0,        4'hF, 0, 0, 0, 32'h0,         LSI_ERR_OK,  1,  1'b0, 1'b1, 32'h0,         0, 0, 13'h0000, LSI_OPC_READ);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("por");
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Reset while waiting for the response, then a late response that must be ignored.
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 30'h0000_0123; wb_sel = 4'hF;
        rx_busy = 1'b0; tx_vld = 1'b0;
        waited = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (tx_busy === 1'b0) break;
            waited++;
        end
        check("rst_reached_wait", 32'(dbg_state), 32'(ST_WAIT));
        rst_n = 1'b0;
        #1;
        check_reset("midwait");
        wb_cyc = 1'b0; wb_stb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        tx_vld = 1'b1; tx_data = 32'hBAD0_BAD0; tx_err = LSI_ERR_OK;
        @(posedge clk); #1;
        tx_vld = 1'b0;
        stray = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (wb_ack || wb_err || rx_vld || !tx_busy) stray++;
        end
        check("late_rsp_stray_activity", 32'(stray), 32'd0);
        check("late_rsp_not_latched", wb_rdat, 32'd0);
        run_vec(mk(1'b0, 30'h0000_0123, 32'h0, 4'hF, 0, 0, 0, 32'h89AB_CDEF, LSI_ERR_OK,
                   3, 1'b1, 1'b0, 32'h89AB_CDEF, 1, 1, 13'h0123, LSI_OPC_READ), "after_rst");

`ifdef WB_LSI_INITIATOR_WATCHDOG_EN
        // No response: REQ entered in cycle 1, err 16 cycles later, then DRAIN.
        run_vec(mk(1'b0, 30'h0000_0033, 32'h0, 4'hF, 0, 100, 0, 32'h0, LSI_ERR_OK,
                   17, 1'b0, 1'b1, 32'h0, 1, 1, 13'h0033, LSI_OPC_READ), "wd_wait");
        @(negedge clk);
        check("wd_drain_state", 32'(dbg_state), 32'(ST_DRAIN));
        check("wd_drain_tx_busy", 32'(tx_busy), 32'd0);
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 30'h0000_0044; wb_sel = 4'hF;
        stray = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (wb_ack || wb_err || rx_vld) stray++;
        end
        check("wd_drain_blocks_stb", 32'(stray), 32'd0);
        @(posedge clk); #1;
        wb_cyc = 1'b0; wb_stb = 1'b0;
        tx_vld = 1'b1; tx_data = 32'hDEAD_0000; tx_err = LSI_ERR_OK;
        @(posedge clk); #1;
        tx_vld = 1'b0;
        @(negedge clk);
        check("wd_drain_exit_state", 32'(dbg_state), 32'(ST_IDLE));
        check("wd_drain_exit_tx_busy", 32'(tx_busy), 32'd1);
        run_vec(mk(1'b0, 30'h0000_0044, 32'h0, 4'hF, 0, 0, 0, 32'h4444_4444, LSI_ERR_OK,
                   3, 1'b1, 1'b0, 32'h4444_4444, 1, 1, 13'h0044, LSI_OPC_READ), "wd_next");
        // Responder never accepts: rx_vld for 16 cycles, err, straight back to IDLE.
        run_vec(mk(1'b1, 30'h0000_0055, 32'h7777_0055, 4'hF, 100, 0, 0, 32'h0, LSI_ERR_OK,
                   17, 1'b0, 1'b1, 32'h0, 16, 0, 13'h0055, LSI_OPC_WRITE), "wd_req");
        @(negedge clk);
        check("wd_req_back_idle", 32'(dbg_state), 32'(ST_IDLE));
`endif

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_lsi_initiator.md
# wb_lsi_initiator

Bridges a Wishbone B3 classic slave port to the LSI request/response channel as an LSI initiator. It issues one LSI read or write per Wishbone cycle, waits for the LSI response, and returns ack/err with read data. It sits between a Wishbone master (boot ROM loader, debug master, soft CPU data port) and any LSI responder, such as the sdcard control wrapper.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024: response watchdog limit in clocks. Used only with the watchdog macro; must be ≥ 2.

Ports:
- host_clk_i  in  1  single clock
- host_rst_ni  in  1  asynchronous active-low reset
- wb_cyc_i  in  1  Wishbone cycle
- wb_stb_i  in  1  Wishbone strobe
- wb_we_i  in  1  write enable
- wb_adr_i  in  30  word address
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte select
- wb_dat_o  out  32  read data
- wb_ack_o  out  1  one-cycle acknowledge
- wb_err_o  out  1  one-cycle error
- lsioc_rx_vld_o  out  1  LSI request valid
- lsioc_rx_sbsp_o  out  13  LSI word address
- lsioc_rx_data_o  out  32  LSI write data
- lsioc_rx_opc_o  out  3  opcode: 000 read, 001 write
- lsioc_rx_busy_i  in  1  responder cannot accept
- lsioc_tx_vld_i  in  1  LSI response valid
- lsioc_tx_data_i  in  32  response data
- lsioc_tx_err_code_i  in  2  00 OK, nonzero error
- lsioc_tx_busy_o  out  1  initiator cannot accept response

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. A DRAIN state exists only with the watchdog macro.
- IDLE: on cyc&stb, check the request.
  - If wb_sel_i != 4'hF or wb_adr_i[29:13] != 0, go to RESP with err=1. No LSI traffic is issued.
  - Otherwise latch adr[12:0], dat, and opc (we ? 001 : 000), then go to REQ.
- REQ: lsioc_rx_vld_o=1 with stable payload. The request is accepted on a clock edge where vld&!busy; then go to WAIT. Payload and vld hold while busy is high.
- WAIT: lsioc_tx_busy_o=0 (busy is 1 in every other state).
  - On tx_vld, latch data and err_code, then go to RESP.
- RESP: drive exactly one cycle of wb_ack_o (err_code==00) or wb_err_o (nonzero or pre-check failure), then go to IDLE.
  - wb_dat_o carries the latched data with the ack and is held until the next response.
  - Write responses also return data; the Wishbone master ignores it.
- Only one transaction is outstanding at a time.
- Dropping cyc mid-transaction does not abort: the LSI exchange completes, and ack/err is still pulsed (the master ignores it).
- A tx_vld pulse arriving outside WAIT is ignored.
- Reset values: all vld/ack/err/busy outputs are 0 except lsioc_tx_busy_o=1. Data/address outputs are 0. State is IDLE.
- Reset asserted mid-transaction returns to IDLE immediately. No response is emitted.

## Timing
- Edge 0 samples stb. rx_vld_o is high in cycle 1.
- Acceptance at the end of cycle 1 (busy low) puts the FSM in WAIT in cycle 2.
- tx_vld sampled at edge N gives ack/err high in cycle N+1.
- Minimum stb→ack latency is 3 cycles with a zero-wait responder.
- Pre-check error: err is high in cycle 1.
- IDLE ignores stb in the cycle after RESP. A classic master has deasserted it by then, so there is no double issue.

## Configuration
Macro WB_LSI_INITIATOR_WATCHDOG_EN.
- Defined:
  - A counter clears on entry to REQ and increments in REQ/WAIT.
  - Reaching TIMEOUT_CYCLES-1 forces RESP with err=1.
  - If timed out in WAIT, the FSM passes through DRAIN after RESP. DRAIN holds tx_busy_o=0 and swallows the next tx_vld, then returns to IDLE. New stb is not serviced until DRAIN completes.
  - If timed out in REQ, rx_vld_o drops and the FSM goes directly to IDLE after RESP.
- Undefined: no counter and no DRAIN; the FSM waits indefinitely.

## Structure
- Package wb_lsi_pkg holds:
  - the state enum (including DRAIN)
  - LSI opcode constants LSI_OPC_READ=3'b000 and LSI_OPC_WRITE=3'b001
  - LSI error codes LSI_ERR_OK=2'b00 and LSI_ERR_BUS=2'b01
- Sub-module wb_lsi_watchdog: a parameterised counter with clear/enable/expired. It is instantiated only under the macro.

## Test plan
- Read, zero-wait: read adr 0x0004; responder returns 0xDEADBEEF/00 one cycle after accept → rx_sbsp=0x0004, opc=000; ack for one cycle at cycle 4; wb_dat_o=0xDEADBEEF; err=0.
- Write with busy: write 0x12345678 to adr 0x1FFF; hold rx_busy_i high for 5 cycles → payload stable for all 5 cycles; exactly one acceptance; opc=001; ack after the response.
- Error response: responder returns err_code 01 → wb_err_o pulses one cycle; wb_ack_o stays 0.
- Pre-check rejection: sel=4'h3, or adr=0x2000 → err in cycle 1; lsioc_rx_vld_o never asserts.
- Reset mid-WAIT: assert host_rst_ni low while waiting → all outputs return to reset values at once; a late tx_vld is ignored; the next read completes normally.
- Watchdog (macro on, TIMEOUT_CYCLES=16): responder never replies → err exactly 16 cycles after REQ entry; a later tx_vld is swallowed in DRAIN; the following transaction gets its own correct data.
